// File: rtl/mem_wb_reg_pkg.sv
// Shared CPU definitions used by the pipeline registers.
// Holds the datapath widths and the writeback-select encodings.
package mem_wb_reg_pkg;

    localparam int unsigned CPU_DATA_W     = 32;
    localparam int unsigned CPU_REG_ADDR_W = 5;
    localparam int unsigned CPU_MEMTOREG_W = 2;

    // Writeback mux select; MEM/WB forwards it without decoding.
    typedef enum logic [CPU_MEMTOREG_W-1:0] {
        MEMTOREG_ALU  = 2'b00,
        MEMTOREG_MEM  = 2'b01,
        MEMTOREG_LINK = 2'b10
    } memtoReg_e;

    function automatic int unsigned memWbBundleWidth(input int unsigned dataW,
                                                     input int unsigned regAddrW,
                                                     input int unsigned memtoRegW);
        return 2 * dataW + regAddrW + 1 + memtoRegW;
    endfunction

endpackage

// File: rtl/mem_wb_reg_pipe_reg.sv
// Generic width-W pipeline D register.
// The reset is synchronous and active-high, and it clears the register to zero.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: free-running, one-cycle capture of memory-stage results.
// Every output is driven directly by a flop.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter int unsigned DATA_W     = CPU_DATA_W,
    parameter int unsigned REG_ADDR_W = CPU_REG_ADDR_W,
    parameter int unsigned MEMTOREG_W = CPU_MEMTOREG_W
) (
    input  logic                  RegWrite_in,
    input  logic [MEMTOREG_W-1:0] MemtoReg_in,
    input  logic [DATA_W-1:0]     D_MEM_read_data_in,
    input  logic [DATA_W-1:0]     D_MEM_read_addr_in,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd_in,
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_W-1:0]     D_MEM_read_data_out,
    output logic [DATA_W-1:0]     D_MEM_read_addr_out,
    output logic [REG_ADDR_W-1:0] MEM_WB_RegisterRd_out,
    output logic                  RegWrite_out,
    output logic [MEMTOREG_W-1:0] MemtoReg_out
);

    pipe_reg #(.W(DATA_W)) readDataReg (
        .clk (clk),
        .rst (rst),
        .d   (D_MEM_read_data_in),
        .q   (D_MEM_read_data_out)
    );

    pipe_reg #(.W(DATA_W)) readAddrReg (
        .clk (clk),
        .rst (rst),
        .d   (D_MEM_read_addr_in),
        .q   (D_MEM_read_addr_out)
    );

    pipe_reg #(.W(REG_ADDR_W)) rdReg (
        .clk (clk),
        .rst (rst),
        .d   (EX_MEM_RegisterRd_in),
        .q   (MEM_WB_RegisterRd_out)
    );

    pipe_reg #(.W(1)) regWriteReg (
        .clk (clk),
        .rst (rst),
        .d   (RegWrite_in),
        .q   (RegWrite_out)
    );

    pipe_reg #(.W(MEMTOREG_W)) memtoRegReg (
        .clk (clk),
        .rst (rst),
        .d   (MemtoReg_in),
        .q   (MemtoReg_out)
    );

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed and seeded-random checks for the MEM/WB pipeline register.
module tb_mem_wb_reg;

    logic        clk;
    logic        rst;
    logic        rwIn;
    logic [1:0]  mtIn;
    logic [31:0] dataIn;
    logic [31:0] addrIn;
    logic [4:0]  rdIn;
    logic [31:0] dataOut;
    logic [31:0] addrOut;
    logic [4:0]  rdOut;
    logic        rwOut;
    logic [1:0]  mtOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        rw;
        logic [1:0]  mt;
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        eRw;
        logic [1:0]  eMt;
        logic [31:0] eData;
        logic [31:0] eAddr;
        logic [4:0]  eRd;
    } vec_t;

    vec_t vecs [7];

    mem_wb_reg #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .MEMTOREG_W (2)
    ) dut (
        .RegWrite_in           (rwIn),
        .MemtoReg_in           (mtIn),
        .D_MEM_read_data_in    (dataIn),
        .D_MEM_read_addr_in    (addrIn),
        .EX_MEM_RegisterRd_in  (rdIn),
        .clk                   (clk),
        .rst                   (rst),
        .D_MEM_read_data_out   (dataOut),
        .D_MEM_read_addr_out   (addrOut),
        .MEM_WB_RegisterRd_out (rdOut),
        .RegWrite_out          (rwOut),
        .MemtoReg_out          (mtOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eRw, input logic [1:0] eMt,
                            input logic [31:0] eData, input logic [31:0] eAddr,
                            input logic [4:0] eRd);
        check({tag, ".data"}, dataOut, eData);
        check({tag, ".addr"}, addrOut, eAddr);
        check({tag, ".rd"}, {27'd0, rdOut}, {27'd0, eRd});
        check({tag, ".rw"}, {31'd0, rwOut}, {31'd0, eRw});
        check({tag, ".mt"}, {30'd0, mtOut}, {30'd0, eMt});
    endtask

    task automatic drive(input logic r, input logic rw, input logic [1:0] mt,
                         input logic [31:0] d, input logic [31:0] a, input logic [4:0] rd);
        rst = r; rwIn = rw; mtIn = mt; dataIn = d; addrIn = a; rdIn = rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pRw;
        logic [1:0]  pMt;
        logic [31:0] pData;
        logic [31:0] pAddr;
        logic [4:0]  pRd;
        logic        pRst;

        //                rst  rw  mt     data          addr          rd     eRw eMt    eData         eAddr         eRd
        vecs[0] = '{1'b1, 1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b0, 2'b00, 32'h00000000, 32'h00000000, 5'd0};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 32'hDEADBEEF, 32'h00001004, 5'd17, 1'b1, 2'b01, 32'hDEADBEEF, 32'h00001004, 5'd17};
        vecs[2] = '{1'b0, 1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31};
        vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 2'b00, 32'h00000000, 32'h00000000, 5'd0};
        vecs[4] = '{1'b0, 1'b1, 2'b10, 32'h80000000, 32'h7FFFFFFF, 5'd16, 1'b1, 2'b10, 32'h80000000, 32'h7FFFFFFF, 5'd16};
        vecs[5] = '{1'b1, 1'b1, 2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd9,  1'b0, 2'b00, 32'h00000000, 32'h00000000, 5'd0};
        vecs[6] = '{1'b0, 1'b0, 2'b01, 32'h12345678, 32'h00000004, 5'd1,  1'b0, 2'b01, 32'h12345678, 32'h00000004, 5'd1};

        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);

        // Table vectors: drive at negedge, sample 1 ns after the capturing edge.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rw, vecs[i].mt, vecs[i].data, vecs[i].addr, vecs[i].rd);
            @(posedge clk);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].eRw, vecs[i].eMt,
                     vecs[i].eData, vecs[i].eAddr, vecs[i].eRd);
        end

        // Reset, then the capture vector must not show up before its edge.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
        @(posedge clk);
        #1;
        checkAll("rstHold", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 32'hDEADBEEF, 32'h00001004, 5'd17);
        #2;
        checkAll("preEdge", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        @(posedge clk);
        #1;
        checkAll("capture", 1'b1, 2'b01, 32'hDEADBEEF, 32'h00001004, 5'd17);

        // Glitches between edges: rst and inputs toggle, then settle before the edge.
        #1;
        drive(1'b1, 1'b0, 2'b10, 32'h0BADF00D, 32'hCAFEF00D, 5'd5);
        #1;
        checkAll("glitchA", 1'b1, 2'b01, 32'hDEADBEEF, 32'h00001004, 5'd17);
        drive(1'b0, 1'b1, 2'b11, 32'h13579BDF, 32'h2468ACE0, 5'd30);
        #2;
        checkAll("glitchB", 1'b1, 2'b01, 32'hDEADBEEF, 32'h00001004, 5'd17);
        @(posedge clk);
        #1;
        checkAll("glitchCap", 1'b1, 2'b11, 32'h13579BDF, 32'h2468ACE0, 5'd30);

        // Seeded back-to-back traffic with a single-cycle reset pulse in the middle.
        void'($urandom(32'd20240611));
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            pRst  = (i == 1000);
            pRw   = 1'($urandom);
            pMt   = 2'($urandom);
            pData = $urandom;
            pAddr = $urandom;
            pRd   = 5'($urandom);
            drive(pRst, pRw, pMt, pData, pAddr, pRd);
            @(posedge clk);
            #1;
            if (pRst) checkAll($sformatf("rnd%0d", i), 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
            else      checkAll($sformatf("rnd%0d", i), pRw, pMt, pData, pAddr, pRd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
MEM/WB pipeline register of the 5-stage CPU. It captures the memory-stage results (load data, ALU result/address, destination register, writeback controls) on each rising clock edge. It presents them to the writeback stage and to the forwarding/hazard logic for one cycle. No stall or flush inputs; the register is free-running.

Parameters:
DATA_W, 32, width of the data-memory read data and of the address/ALU-result path
REG_ADDR_W, 5, width of a register-file index
MEMTOREG_W, 2, width of the writeback mux select

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
RegWrite_in  input  1  register-file write enable from EX/MEM
MemtoReg_in  input  MEMTOREG_W  writeback mux select from EX/MEM
D_MEM_read_data_in  input  DATA_W  data read from data memory
D_MEM_read_addr_in  input  DATA_W  memory address / ALU result from EX/MEM
EX_MEM_RegisterRd_in  input  REG_ADDR_W  destination register index from EX/MEM
D_MEM_read_data_out  output  DATA_W  registered read data
D_MEM_read_addr_out  output  DATA_W  registered address / ALU result
MEM_WB_RegisterRd_out  output  REG_ADDR_W  registered destination register index
RegWrite_out  output  1  registered write enable
MemtoReg_out  output  MEMTOREG_W  registered writeback select

Positional port order, which existing instantiations rely on:
- RegWrite_in, MemtoReg_in, D_MEM_read_data_in, D_MEM_read_addr_in, EX_MEM_RegisterRd_in, clk, rst
- then D_MEM_read_data_out, D_MEM_read_addr_out, MEM_WB_RegisterRd_out, RegWrite_out, MemtoReg_out

Behaviour:
- All outputs come directly from flip-flops; no combinational input-to-output path.
- Rising edge of clk with rst=1: every output goes to 0. This covers RegWrite_out=0, MemtoReg_out=2'b00, both data outputs 32'h0 and Rd_out=5'd0.
- Rising edge with rst=0: each output takes the value its input had just before the edge.
- Latency is exactly 1 cycle. Values hold until the next edge.
- rst is sampled only at the edge. Asserting or deasserting it between edges has no effect until the next edge.
- A single-cycle rst pulse mid-stream clears the outputs for exactly one cycle. Capture resumes at the following edge.
- No power-on initial value is guaranteed. Outputs are undefined until the first rising edge, which either resets or captures.
- Inputs may change every cycle; every field is captured independently with no gating.
- No width conversion. All widths match input to output exactly and all values are unsigned.

Decomposition:
- Shared CPU package holds DATA_W=32, REG_ADDR_W=5 and the MemtoReg encodings: 2'b00 ALU result, 2'b01 memory data, 2'b10 link/PC+4. This block passes MemtoReg through without decoding it.
- One sub-module is natural: pipe_reg, a generic parameterised width-W D register with synchronous active-high reset to 0.
- mem_wb_reg instantiates pipe_reg once per field, or once on the concatenated 72-bit bundle.

Test Plan:
- Reset: drive all inputs to 1s and hold rst=1 across an edge. Required: all outputs 0 after that edge.
- Capture: RegWrite_in=1, MemtoReg_in=2'b01, read_data=32'hDEADBEEF, addr=32'h0000_1004, Rd=5'd17, rst=0. Required: exactly those values on the outputs after one edge, unchanged before the edge.
- Back-to-back: change every input each cycle for about 2000 cycles with seeded random values. Required: each output equals its input from the previous cycle, every cycle.
- Mid-stream reset: a one-cycle rst pulse during random traffic. Required: outputs 0 for exactly one cycle, then the next captured inputs appear.
- Edge values: Rd=5'd31, MemtoReg=2'b11, data=32'hFFFFFFFF then 32'h0. Required: full-width pass-through with no truncation or sign effects.
- Between-edge glitch: toggle inputs and rst between edges. Required: outputs unchanged until the next rising edge.
